// File: rtl/bp_me_pkg.sv
// Shared types and configuration helpers for the memory-engine I/O path.
// Holds the processor config selector, the message width derived from it,
// the default I/O NoC credit budget and the I/O command arbiter state enum.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg,
        e_bp_multicore_cfg
    } bp_params_e;

    // Default number of I/O commands allowed in flight
    localparam int unsigned io_noc_max_credits_p = 4;

    typedef enum logic [1:0] {
        e_run,
        e_drain,
        e_quiesced
    } bp_io_arb_state_e;

    // Width of one CCE memory message (header plus data) for a given config
    function automatic int unsigned bp_cce_mem_msg_width(input bp_params_e cfg);
        int unsigned w;
        unique case (cfg)
            e_bp_unicore_cfg:   w = 96;
            e_bp_multicore_cfg: w = 128;
            default:            w = 64;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bp_me_io_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding I/O commands.
// A push and a pop may occur in the same cycle, including when full.
module bp_me_io_arb_id_fifo #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [cnt_width_lp-1:0] cnt_q;
    logic                    push, pop;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == cnt_width_lp'(els_p));
    assign pop     = yumi_i & ~empty_o;
    assign push    = v_i & (~full_o | pop);
    assign data_o  = mem_q[rptr_q];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// Arbitrates several requesters onto one downstream I/O command channel with
// credit-based flow control, and routes in-order responses back by ID.
// Supports a quiesce/drain handshake and a sticky error for orphan responses.
// Optional: define BP_IO_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.
module bp_me_io_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
    parameter int unsigned num_req_p     = 2,
    parameter int unsigned max_credits_p = io_noc_max_credits_p,
    localparam int unsigned cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,

    input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                      req_cmd_v_i,
    output logic [num_req_p-1:0]                      req_cmd_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0]           io_cmd_o,
    output logic                                      io_cmd_v_o,
    input  logic                                      io_cmd_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0]           io_resp_i,
    input  logic                                      io_resp_v_i,
    output logic                                      io_resp_ready_and_o,

    output logic [cce_mem_msg_width_lp-1:0]           req_resp_o,
    output logic [num_req_p-1:0]                      req_resp_v_o,
    input  logic [num_req_p-1:0]                      req_resp_ready_and_i,

    input  logic                                      quiesce_i,
    output logic                                      quiesced_o,
    output logic                                      err_o
);

    localparam int unsigned id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(max_credits_p + 1);

    bp_io_arb_state_e              state_q;
    logic                          quiesced_q;
    logic                          err_q;
    logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
    logic                          grant_held_q;
    logic [id_width_lp-1:0]        grant_id_q;

    logic [cce_mem_msg_width_lp-1:0] cmd_arr [num_req_p];
    logic [id_width_lp-1:0]        sel_id, grant_id, head_id;
    logic                          sel_v, can_grant, cmd_fire, resp_fire;
    logic                          fifo_empty, fifo_full;

    // New grants only while running, not quiescing, and with a free credit
    assign can_grant = (state_q == e_run) & ~quiesce_i & ~fifo_full
                     & (cnt_q < cnt_width_lp'(max_credits_p));

`ifdef BP_IO_ARB_RR_EN
    logic [id_width_lp-1:0] rr_q;

    // Round-robin pick: first valid requester at or after the pointer
    always_comb begin
        int idx;
        idx    = 0;
        sel_id = '0;
        sel_v  = 1'b0;
        for (int i = int'(num_req_p) - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(num_req_p)) idx = idx - int'(num_req_p);
            if (req_cmd_v_i[idx]) begin
                sel_id = idx[id_width_lp-1:0];
                sel_v  = 1'b1;
            end
        end
    end

    // Priority restarts just past the requester that was last accepted
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q <= '0;
        end else if (cmd_fire) begin
            rr_q <= (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest valid index wins (scan high to low)
    always_comb begin
        sel_id = '0;
        sel_v  = 1'b0;
        for (int i = int'(num_req_p) - 1; i >= 0; i--) begin
            if (req_cmd_v_i[i]) begin
                sel_id = i[id_width_lp-1:0];
                sel_v  = 1'b1;
            end
        end
    end
`endif

    // A held grant pins the selection so io_cmd_o stays stable until yumi
    assign grant_id   = grant_held_q ? grant_id_q : sel_id;
    assign io_cmd_v_o = reset_n_i & (grant_held_q | (can_grant & sel_v));
    assign cmd_fire   = io_cmd_v_o & io_cmd_yumi_i;

    // Unpack the flat command bus into per-requester slices
    always_comb begin
        for (int i = 0; i < int'(num_req_p); i++) begin
            cmd_arr[i] = req_cmd_i[i*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
        end
    end

    assign io_cmd_o = cmd_arr[grant_id];

    // Accept strobe goes only to the granted requester
    always_comb begin
        req_cmd_yumi_o           = '0;
        req_cmd_yumi_o[grant_id] = cmd_fire;
    end

    // Orphan responses (nothing outstanding) are always accepted and dropped
    assign io_resp_ready_and_o = fifo_empty ? 1'b1 : req_resp_ready_and_i[head_id];
    assign resp_fire           = io_resp_v_i & io_resp_ready_and_o & ~fifo_empty;
    assign req_resp_o          = io_resp_i;

    // Response valid is steered to the oldest outstanding requester
    always_comb begin
        req_resp_v_o          = '0;
        req_resp_v_o[head_id] = io_resp_v_i & ~fifo_empty;
    end

    // Credit count next state; simultaneous issue and return cancel out
    always_comb begin
        unique case ({cmd_fire, resp_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    bp_me_io_arb_id_fifo #(
        .width_p (id_width_lp),
        .els_p   (max_credits_p)
    ) id_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (grant_id),
        .v_i       (cmd_fire),
        .yumi_i    (resp_fire),
        .data_o    (head_id),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // Credit counter, grant hold and sticky error flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q        <= '0;
            grant_held_q <= 1'b0;
            grant_id_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cmd_fire) begin
                grant_held_q <= 1'b0;
            end else if (io_cmd_v_o) begin
                grant_held_q <= 1'b1;
                grant_id_q   <= grant_id;
            end
            if (io_resp_v_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Quiesce FSM; drain completes on the cycle the last credit returns
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_run;
            quiesced_q <= 1'b0;
        end else begin
            unique case (state_q)
                e_run: begin
                    if (quiesce_i && (!grant_held_q || cmd_fire)) begin
                        state_q <= e_drain;
                    end
                end
                e_drain: begin
                    if (cnt_d == '0) begin
                        state_q    <= e_quiesced;
                        quiesced_q <= 1'b1;
                    end
                end
                e_quiesced: begin
                    if (!quiesce_i) begin
                        state_q    <= e_run;
                        quiesced_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= e_run;
                    quiesced_q <= 1'b0;
                end
            endcase
        end
    end

    assign quiesced_o = quiesced_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Scoreboard bench for the I/O command arbiter (2 requesters, 4 credits).
// Stimulus pushes expected grant IDs; a negedge monitor pops and compares on
// every command and response handshake.
module tb_bp_me_io_cmd_arbiter;
    import bp_me_pkg::*;

    localparam int unsigned W  = bp_cce_mem_msg_width(e_bp_default_cfg);
    localparam int unsigned NR = 2;
    localparam logic [63:0] RESP_DATA = 64'hBEEF_0000_1234_5678;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b1;
    logic [NR*W-1:0] req_cmd_i;
    logic [NR-1:0]   req_cmd_v_i = '0;
    logic [NR-1:0]   req_cmd_yumi_o;
    logic [W-1:0]    io_cmd_o;
    logic            io_cmd_v_o;
    logic            io_cmd_yumi_i = 1'b0;
    logic [W-1:0]    io_resp_i;
    logic            io_resp_v_i = 1'b0;
    logic            io_resp_ready_and_o;
    logic [W-1:0]    req_resp_o;
    logic [NR-1:0]   req_resp_v_o;
    logic [NR-1:0]   req_resp_ready_and_i = '0;
    logic            quiesce_i = 1'b0;
    logic            quiesced_o;
    logic            err_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cmd_q[$];
    int exp_resp_q[$];

    function automatic logic [63:0] cmd_val(input int id);
        return 64'hC0DE_0000_0000_0000 | 64'(id);
    endfunction

    assign req_cmd_i = {cmd_val(1), cmd_val(0)};
    assign io_resp_i = RESP_DATA;

    always #5 clk_i = ~clk_i;

    bp_me_io_cmd_arbiter dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .req_cmd_i            (req_cmd_i),
        .req_cmd_v_i          (req_cmd_v_i),
        .req_cmd_yumi_o       (req_cmd_yumi_o),
        .io_cmd_o             (io_cmd_o),
        .io_cmd_v_o           (io_cmd_v_o),
        .io_cmd_yumi_i        (io_cmd_yumi_i),
        .io_resp_i            (io_resp_i),
        .io_resp_v_i          (io_resp_v_i),
        .io_resp_ready_and_o  (io_resp_ready_and_o),
        .req_resp_o           (req_resp_o),
        .req_resp_v_o         (req_resp_v_o),
        .req_resp_ready_and_i (req_resp_ready_and_i),
        .quiesce_i            (quiesce_i),
        .quiesced_o           (quiesced_o),
        .err_o                (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_grant(input int id);
        exp_cmd_q.push_back(id);
        exp_resp_q.push_back(id);
    endtask

    // Monitor: compare each handshake against the scoreboard queues
    int mid;
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (io_cmd_v_o && io_cmd_yumi_i) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_cmd", 64'(io_cmd_v_o), 64'd0);
                end else begin
                    mid = exp_cmd_q.pop_front();
                    check("cmd_data", 64'(io_cmd_o), cmd_val(mid));
                    check("cmd_yumi", 64'(req_cmd_yumi_o), 64'(1) << mid);
                end
            end
            if (io_resp_v_i && io_resp_ready_and_o) begin
                if (exp_resp_q.size() == 0) begin
                    check("orphan_resp_v", 64'(req_resp_v_o), 64'd0);
                end else begin
                    mid = exp_resp_q.pop_front();
                    check("resp_route", 64'(req_resp_v_o), 64'(1) << mid);
                    check("resp_data", 64'(req_resp_o), RESP_DATA);
                end
            end
        end
    end

    logic [1:0] fp_tbl [4] = '{2'b11, 2'b10, 2'b11, 2'b10};
    bit rr_mode;

    initial begin
`ifdef BP_IO_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        // Reset values
        req_cmd_v_i = 2'b11;
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
        check("rst_cmd_yumi", 64'(req_cmd_yumi_o), 64'd0);
        check("rst_resp_v", 64'(req_resp_v_o), 64'd0);
        check("rst_quiesced", 64'(quiesced_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        req_cmd_v_i = 2'b00;
        tick();
        tick();
        reset_n_i = 1'b1;

        // Four grants alternate 0,1,0,1 then credits run out
        for (int i = 0; i < 2; i++) begin
            expect_grant(0);
            expect_grant(1);
        end
        io_cmd_yumi_i = 1'b1;
        req_resp_ready_and_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_cmd_v_i = rr_mode ? 2'b11 : fp_tbl[i];
            tick();
        end
        req_cmd_v_i = 2'b11;
        #1 check("credit_full_stall", 64'(io_cmd_v_o), 64'd0);
        tick();
        check("credit_full_hold", 64'(io_cmd_v_o), 64'd0);

        // One response frees one credit, not re-enabled in the same cycle
        io_resp_v_i = 1'b1;
        #1 check("no_same_cycle_reenable", 64'(io_cmd_v_o), 64'd0);
        expect_grant(0);
        tick();
        io_resp_v_i = 1'b0;
        tick();
        check("one_more_then_stall", 64'(io_cmd_v_o), 64'd0);

        // Pop at full, then simultaneous issue and return keeps count at 3
        req_cmd_v_i = 2'b10;
        io_resp_v_i = 1'b1;
        tick();
        expect_grant(1);
        tick();
        io_resp_v_i   = 1'b0;
        io_cmd_yumi_i = 1'b0;
        #1 check("count_unchanged_v", 64'(io_cmd_v_o), 64'd1);
        tick();
        req_cmd_v_i = 2'b11;
        #1 check("grant_hold_data", 64'(io_cmd_o), cmd_val(1));
        expect_grant(1);
        io_cmd_yumi_i = 1'b1;
        tick();
        check("count_full_again", 64'(io_cmd_v_o), 64'd0);

        // Drain with backpressure from the head requester
        req_cmd_v_i   = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b1;
        req_resp_ready_and_i = 2'b01;
        #1 check("resp_backpressure", 64'(io_resp_ready_and_o), 64'd0);
        check("resp_v_head", 64'(req_resp_v_o), 64'b10);
        req_resp_ready_and_i = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        io_resp_v_i = 1'b0;

        // Quiesce with three outstanding
        req_cmd_v_i   = 2'b01;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) expect_grant(0);
        for (int i = 0; i < 3; i++) tick();
        quiesce_i = 1'b1;
        #1 check("quiesce_no_grant", 64'(io_cmd_v_o), 64'd0);
        tick();
        check("drain_no_grant", 64'(io_cmd_v_o), 64'd0);
        check("drain_not_quiesced", 64'(quiesced_o), 64'd0);
        io_resp_v_i = 1'b1;
        tick();
        tick();
        check("quiesced_early", 64'(quiesced_o), 64'd0);
        tick();
        io_resp_v_i = 1'b0;
        check("quiesced_rise", 64'(quiesced_o), 64'd1);
        check("quiesced_no_grant", 64'(io_cmd_v_o), 64'd0);
        quiesce_i     = 1'b0;
        io_cmd_yumi_i = 1'b0;
        tick();
        check("resume_quiesced_low", 64'(quiesced_o), 64'd0);
        check("resume_grant", 64'(io_cmd_v_o), 64'd1);
        req_cmd_v_i = 2'b00;

        // Orphan response sets the sticky error
        io_resp_v_i = 1'b1;
        req_resp_ready_and_i = 2'b00;
        #1 check("orphan_ready", 64'(io_resp_ready_and_o), 64'd1);
        tick();
        io_resp_v_i = 1'b0;
        check("err_set", 64'(err_o), 64'd1);
        tick();
        tick();
        check("err_sticky", 64'(err_o), 64'd1);

        // Reset mid-stream with two outstanding and a pending command
        req_resp_ready_and_i = 2'b11;
        req_cmd_v_i   = 2'b01;
        io_cmd_yumi_i = 1'b1;
        expect_grant(0);
        expect_grant(0);
        tick();
        tick();
        io_cmd_yumi_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_mid_cmd_v", 64'(io_cmd_v_o), 64'd0);
        check("rst_mid_cmd_yumi", 64'(req_cmd_yumi_o), 64'd0);
        check("rst_mid_resp_v", 64'(req_resp_v_o), 64'd0);
        check("rst_mid_quiesced", 64'(quiesced_o), 64'd0);
        check("rst_mid_err", 64'(err_o), 64'd0);
        exp_resp_q.delete();
        tick();
        reset_n_i   = 1'b1;
        req_cmd_v_i = 2'b00;

        // Stale response after reset is an orphan
        io_resp_v_i = 1'b1;
        tick();
        io_resp_v_i = 1'b0;
        check("post_rst_err", 64'(err_o), 64'd1);

        // Full credit budget is available again after reset
        req_cmd_v_i   = 2'b01;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) expect_grant(0);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_credits", 64'(io_cmd_v_o), 64'd0);
        req_cmd_v_i   = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        io_resp_v_i = 1'b0;
        tick();

        check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
        check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
